sub_borrow_ahead_seq: RTL and testbench

SUB_BORROW_AHEAD_SEQ -- requirements
Module: sub_borrow_ahead_seq

---
 rtl/sub_borrow_ahead_seq.sv | 126 ++++++++++++
 tb/tb_sub_borrow_ahead_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sub_borrow_ahead_seq.sv
// Serial subtractor: one 4-bit slice per cycle with borrow lookahead inside the slice.
// Optional macro SUB_ABS_EN adds a FIX cycle so that diff = |a - b - bin| and neg carries the sign.
module sub_borrow_ahead_seq #(
  parameter int NSLICE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*NSLICE-1:0] a,
  input  logic [4*NSLICE-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*NSLICE-1:0] diff,
  output logic                bout,
  output logic                neg,
  output logic                zero
);
  localparam int W  = 4 * NSLICE;
  localparam int CW = $clog2(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef SUB_ABS_EN
    FIX  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q, res_q, diff_q;
  logic          brw_q, busy_q, done_q, bout_q, zero_q;

  logic [3:0]    g, p, sd;
  logic [4:0]    br;
  logic [W-1:0]  res_d;

  // Operands shift right each cycle, so the active slice is always bits [3:0];
  // result slices enter from the top and are fully aligned after NSLICE cycles.
  always_comb begin
    g     = ~a_q[3:0] & b_q[3:0];
    p     = ~(a_q[3:0] ^ b_q[3:0]);
    br    = '0;
    br[0] = brw_q;
    br[1] = g[0] | (p[0] & br[0]);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br[0]);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br[0]);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & br[0]);
    sd    = a_q[3:0] ^ b_q[3:0] ^ br[3:0];
    res_d = {sd, res_q[W-1:4]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          brw_q <= br[4];
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef SUB_ABS_EN
            state_q <= FIX;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= br[4];
            zero_q  <= (res_d == '0);
`endif
          end
        end
`ifdef SUB_ABS_EN
        // Entered regardless of sign to keep latency fixed; zero reflects the raw result.
        FIX: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          diff_q  <= brw_q ? (~res_q + W'(1)) : res_q;
          bout_q  <= brw_q;
          zero_q  <= (res_q == '0);
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign neg  = bout_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_sub_borrow_ahead_seq.sv
// Self-checking bench for sub_borrow_ahead_seq: directed vectors plus randomized operands
// against an arithmetic reference; honours SUB_ABS_EN if defined for the build.
module tb_sub_borrow_ahead_seq;
  localparam int NSLICE = 4;
  localparam int W      = 4 * NSLICE;
`ifdef SUB_ABS_EN
  localparam int LAT = NSLICE + 2;
  localparam bit ABS = 1'b1;
`else
  localparam int LAT = NSLICE + 1;
  localparam bit ABS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, neg, zero;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  sub_borrow_ahead_seq #(.NSLICE(NSLICE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .neg(neg), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; the top bit of the wide result is the borrow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] ed, output logic eb, output logic ez);
    logic [W:0] r;
    r  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    eb = r[W];
    ez = (r[W-1:0] == '0);
    ed = r[W-1:0];
    if (ABS && eb) ed = ~ed + 1'b1;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input bit noise, input string tag);
    logic [W-1:0] ed, held;
    logic         eb, ez;
    int           k;
    bit           stable;
    model(ta, tb_, tbin, ed, eb, ez);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; bin = tbin;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    k = 1; held = diff; stable = 1'b1;
    while (done !== 1'b1 && k < 4 * LAT) begin
      start = (noise && (k == 2 || k == 3)) ? 1'b1 : 1'b0;
      if (busy !== 1'b1 || diff !== held) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check($sformatf("%s.latency", tag), k, LAT);
    check($sformatf("%s.diff", tag), diff, ed);
    check($sformatf("%s.bout", tag), bout, eb);
    check($sformatf("%s.neg", tag), neg, eb);
    check($sformatf("%s.zero", tag), zero, ez);
    check($sformatf("%s.busy_stable", tag), stable, 1);
    @(negedge clk);
    check($sformatf("%s.done_pulse", tag), done, 0);
    check($sformatf("%s.idle", tag), busy, 0);
    check($sformatf("%s.diff_hold", tag), diff, ed);
  endtask

  initial begin
    logic [W-1:0] ra, rb, e1, e2;
    logic         e1b, e1z, e2b, e2z;
    int           k;
    bit           seen;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.diff", diff, 0);
    check("rst.bout", bout, 0);
    check("rst.neg", neg, 0);
    check("rst.zero", zero, 0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 1'b0, "v1234");
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, "v0m1");
    run_op(16'h0005, 16'h0005, 1'b1, 1'b0, "veqb");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "vzero");
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "vmax");
    run_op(16'h00FF, 16'h000F, 1'b0, 1'b1, "ignore");

    // Abort mid-operation; outputs currently hold a nonzero result from the run above.
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0, "prerst");
    @(negedge clk);
    start = 1'b1; a = 16'h4321; b = 16'h1111; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.diff", diff, 0);
    check("abort.bout", bout, 0);
    check("abort.neg", neg, 0);
    check("abort.zero", zero, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort.no_done", seen, 0);
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, "postrst");

    // start held high across DONE: second op begins on the first IDLE cycle.
    model(16'h0F0F, 16'h00FF, 1'b1, e1, e1b, e1z);
    model(16'h1000, 16'h2000, 1'b0, e2, e2b, e2z);
    @(negedge clk);
    start = 1'b1; a = 16'h0F0F; b = 16'h00FF; bin = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 4 * LAT);
    check("b2b.lat1", k, LAT);
    check("b2b.diff1", diff, e1);
    check("b2b.bout1", bout, e1b);
    a = 16'h1000; b = 16'h2000; bin = 1'b0;
    @(negedge clk);
    check("b2b.idle", busy, 0);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 4 * LAT) begin
      @(negedge clk);
      k++;
    end
    check("b2b.lat2", k, LAT);
    check("b2b.diff2", diff, e2);
    check("b2b.bout2", bout, e2b);
    check("b2b.zero2", zero, e2z);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ra;
        2: ra = '0;
        default: ra = '1;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
